// File: rtl/mem_loader.sv
// ============================================================================
//  Module      : mem_loader
//  Description : Packs a big-endian byte stream into 32-bit words and writes
//                them to consecutive memory addresses, keeping a running sum.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_loader #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              abort,
    output logic [ADDR_W-1:0] w_addr,
    output logic              w_en,
    output logic [31:0]       din,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RECV  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_byte_idx;
    logic [CNT_W-1:0]  r_word_idx;
    logic [23:0]       r_shift;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_din;
    logic [31:0]       r_checksum;

    logic              w_start_ok;
    logic              w_accept;
    logic              w_last_byte;
    logic              w_last_word;
    logic              w_write_ok;
    logic [ADDR_W-1:0] w_idx_ext;
    logic [ADDR_W-1:0] w_next_addr;
    logic [31:0]       w_word;

    assign w_start_ok  = (r_state == c_IDLE) && start && !abort;
    assign w_accept    = (r_state == c_RECV) && in_valid && !abort;
    assign w_last_byte = (r_byte_idx == 2'd3);
    assign w_last_word = ((r_word_idx + CNT_W'(1)) == r_count);
    assign w_write_ok  = (r_state == c_WRITE) && !abort;
    assign w_idx_ext   = ADDR_W'(r_word_idx);
    assign w_next_addr = r_base + w_idx_ext;
    assign w_word      = {r_shift, in_byte};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; abort overrides every busy state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = (word_count == '0) ? c_DONE : c_RECV;
                end
            end
            c_RECV: begin
                if (abort) begin
                    w_state_nxt = c_IDLE;
                end else if (w_accept && w_last_byte) begin
                    w_state_nxt = c_WRITE;
                end
            end
            c_WRITE: begin
                if (abort) begin
                    w_state_nxt = c_IDLE;
                end else begin
                    w_state_nxt = w_last_word ? c_DONE : c_RECV;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        w_en     = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            c_IDLE:  busy     = 1'b0;
            c_RECV:  in_ready = 1'b1;
            c_WRITE: w_en     = !abort;
            c_DONE:  done     = !abort;
            default: busy     = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: parameter latches, byte packing, write port, checksum
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= '0;
            r_count    <= '0;
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_shift    <= '0;
            r_waddr    <= '0;
            r_din      <= '0;
            r_checksum <= '0;
        end else begin
            if (w_start_ok) begin
                r_base     <= base_addr;
                r_count    <= word_count;
                r_byte_idx <= '0;
                r_word_idx <= '0;
                r_checksum <= '0;
            end

            // The full word is captured on the 4th byte so it is stable
            // on the write port for the whole WRITE cycle and afterwards.
            if (w_accept) begin
                r_shift    <= w_word[23:0];
                r_byte_idx <= r_byte_idx + 2'd1;
                if (w_last_byte) begin
                    r_din   <= w_word;
                    r_waddr <= w_next_addr;
                end
            end

            if (w_write_ok) begin
                r_checksum <= r_checksum + r_din;
                r_byte_idx <= '0;
                if (!w_last_word) begin
                    r_word_idx <= r_word_idx + CNT_W'(1);
                end
            end
        end
    end

    assign w_addr   = r_waddr;
    assign din      = r_din;
    assign checksum = r_checksum;

endmodule

`default_nettype wire
